register_write_arbiter: RTL and testbench

Shares the single write port of the 32x32 general-purpose register file between several writeback producers (ALU, load unit, multiply/divide unit) using round-robin arbitration with a valid/grant handshake. It registers the winning write and drives the register file's write port one cycle later. A 32-bit pending scoreboard tracks destination registers reserved at decode and not yet written back, so the issue logic can stall on RAW hazards.

---
 rtl/register_write_arbiter.sv | 133 +++++++++++++
 tb/tb_register_write_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter for the GPR file write port, with a registered write
// stage and a pending-destination scoreboard used by issue for RAW stalls.
module register_write_arbiter #(
  parameter int REQUESTERS = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REQUESTERS-1:0]     request,
  input  logic [5*REQUESTERS-1:0]   request_address,
  input  logic [32*REQUESTERS-1:0]  request_data,
  output logic [REQUESTERS-1:0]     grant,
  output logic                      write_enable,
  output logic [4:0]                write_address,
  output logic [31:0]               write_data,
  input  logic                      mark_enable,
  input  logic [4:0]                mark_address,
  output logic [31:0]               pending
);

  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [PW:0] NREQ = (PW+1)'(REQUESTERS);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_s;
  logic          win_vld_s;
  logic [PW:0]   cand_s;
  logic [PW:0]   nxt_s;
  logic [4:0]    win_addr_s;
  logic [31:0]   win_data_s;

  logic          we_q, we_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   pending_q, pending_d;

  // Search from the priority pointer, wrapping, for the first active request
  always_comb begin
    win_s     = '0;
    win_vld_s = 1'b0;
    cand_s    = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      cand_s = {1'b0, ptr_q} + (PW+1)'(k);
      cand_s = (cand_s >= NREQ) ? (cand_s - NREQ) : cand_s;
      if (!win_vld_s && request[cand_s[PW-1:0]]) begin
        win_vld_s = 1'b1;
        win_s     = cand_s[PW-1:0];
      end else begin
        win_vld_s = win_vld_s;
      end
    end
    if (reset) begin
      win_vld_s = 1'b0;
    end else begin
      win_vld_s = win_vld_s;
    end
  end

  // One-hot grant and the winning producer's payload
  always_comb begin
    grant      = '0;
    win_addr_s = request_address[32'(win_s)*5 +: 5];
    win_data_s = request_data[32'(win_s)*32 +: 32];
    if (win_vld_s) begin
      grant[win_s] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  // Next pointer: one past the winner, holding when nothing was granted
  always_comb begin
    nxt_s = {1'b0, win_s} + {{PW{1'b0}}, 1'b1};
    ptr_d = ptr_q;
    if (win_vld_s) begin
      ptr_d = (nxt_s >= NREQ) ? '0 : nxt_s[PW-1:0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Write stage: r0 requests are consumed but never reach the register file
  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (win_vld_s) begin
      we_d = (win_addr_s != 5'd0);
      wa_d = win_addr_s;
      wd_d = win_data_s;
    end else begin
      we_d = 1'b0;
    end
  end

  // Scoreboard: a fresh reservation beats a same-cycle writeback clear
  always_comb begin
    pending_d = pending_q;
    if (we_q) begin
      pending_d[wa_q] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (mark_enable && (mark_address != 5'd0)) begin
      pending_d[mark_address] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q     <= '0;
      we_q      <= 1'b0;
      wa_q      <= 5'd0;
      wd_q      <= 32'd0;
      pending_q <= 32'd0;
    end else begin
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      pending_q <= pending_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = wa_q;
  assign write_data    = wd_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Randomized bench for register_write_arbiter: a queue-based scoreboard of
// expected register-file writes, checked by an independent negedge monitor.
module tb_register_write_arbiter;
  localparam int N = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      request = '0;
  logic [5*N-1:0]    request_address = '0;
  logic [32*N-1:0]   request_data = '0;
  logic [N-1:0]      grant;
  logic              write_enable;
  logic [4:0]        write_address;
  logic [31:0]       write_data;
  logic              mark_enable = 1'b0;
  logic [4:0]        mark_address = 5'd0;
  logic [31:0]       pending;

  register_write_arbiter #(.REQUESTERS(N)) dut (
    .clock(clock), .reset(reset), .request(request),
    .request_address(request_address), .request_data(request_data),
    .grant(grant), .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .mark_enable(mark_enable),
    .mark_address(mark_address), .pending(pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;

  // Reference model state: producers, priority pointer, scoreboard
  bit          p_act[N];
  logic [4:0]  p_addr[N];
  logic [31:0] p_data[N];
  int          ptr = 0;
  logic [31:0] exp_pend = 32'd0;
  bit          cur_we = 1'b0;
  logic [4:0]  cur_wa = 5'd0;
  logic        m_en = 1'b0;
  logic [4:0]  m_addr = 5'd0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got %h expected %h", nm, cyc, act, exp);
  endfunction

  // One clock cycle: drive, check grant/pending, advance model, push writes.
  task automatic step(input bit hold);
    logic [N-1:0] eg;
    logic [31:0]  np;
    int           win;
    int           idx;
    for (int i = 0; i < N; i++) begin
      request[i]                 = p_act[i];
      request_address[5*i +: 5]  = p_addr[i];
      request_data[32*i +: 32]   = p_data[i];
    end
    mark_enable  = m_en;
    mark_address = m_addr;
    #1;
    chk("pending", pending, exp_pend);
    eg  = '0;
    win = -1;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (win < 0 && p_act[idx]) win = idx;
      end
    end
    if (win >= 0) eg[win] = 1'b1;
    chk("grant", 32'(grant), 32'(eg));
    np = exp_pend;
    if (cur_we) np[cur_wa] = 1'b0;
    if (m_en && m_addr != 5'd0) np[m_addr] = 1'b1;
    if (reset) begin
      np     = 32'd0;
      ptr    = 0;
      cur_we = 1'b0;
    end else if (win >= 0) begin
      ptr    = (win + 1) % N;
      cur_we = (p_addr[win] != 5'd0);
      cur_wa = p_addr[win];
      if (cur_we) exp_q.push_back('{cyc + 1, p_addr[win], p_data[win]});
      if (!hold) p_act[win] = 1'b0;
    end else begin
      cur_we = 1'b0;
    end
    exp_pend = np;
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // Monitor: every cycle, either the next scheduled write or an idle port
  always @(negedge clock) begin
    wr_t e;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("write_enable", 32'(write_enable), 32'd1);
        chk("write_address", 32'(write_address), 32'(e.a));
        chk("write_data", write_data, e.d);
      end else begin
        chk("write_enable_idle", 32'(write_enable), 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      p_act[i]  = 1'b1;
      p_addr[i] = 5'(i + 1);
      p_data[i] = 32'hA + 32'(i);
    end
    // Settle registers under reset before checking starts
    request = '1;
    @(posedge clock);
    cyc = 1;
    #1;
    mon_en = 1'b1;

    // Reset with all requests high, then round-robin on held requests
    step(1'b1);
    step(1'b1);
    reset = 1'b0;
    repeat (7) step(1'b1);

    // Priority rotation: grant 1 leaves P=2, then 011 wraps to 0 first
    for (int i = 0; i < N; i++) p_act[i] = 1'b0;
    step(1'b0);
    p_act[1] = 1'b1; p_addr[1] = 5'd4; p_data[1] = 32'h1;
    step(1'b0);
    p_act[0] = 1'b1; p_addr[0] = 5'd6; p_data[0] = 32'h2;
    p_act[1] = 1'b1; p_addr[1] = 5'd7; p_data[1] = 32'h3;
    step(1'b0);
    step(1'b0);

    // r0 request plus a mark of r0
    p_act[2] = 1'b1; p_addr[2] = 5'd0; p_data[2] = 32'hFFFF_FFFF;
    m_en = 1'b1; m_addr = 5'd0;
    step(1'b0);
    m_en = 1'b0;
    step(1'b0);
    step(1'b0);

    // Scoreboard: mark r5, write it back, then again with a re-mark
    m_en = 1'b1; m_addr = 5'd5;
    step(1'b0);
    m_en = 1'b0;
    p_act[0] = 1'b1; p_addr[0] = 5'd5; p_data[0] = 32'h1234;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    m_en = 1'b1; m_addr = 5'd5;
    step(1'b0);
    m_en = 1'b0;
    p_act[0] = 1'b1; p_addr[0] = 5'd5; p_data[0] = 32'h1234;
    step(1'b0);
    m_en = 1'b1; m_addr = 5'd5;
    step(1'b0);
    m_en = 1'b0;
    step(1'b0);
    step(1'b0);

    // Withdrawal: requester 1 drops before its turn, P must stay at 1
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    p_act[0] = 1'b1; p_addr[0] = 5'd8;  p_data[0] = 32'h11;
    p_act[1] = 1'b1; p_addr[1] = 5'd9;  p_data[1] = 32'h22;
    step(1'b0);
    p_act[1] = 1'b0;
    step(1'b0);
    p_act[0] = 1'b1; p_addr[0] = 5'd12; p_data[0] = 32'h44;
    p_act[1] = 1'b1; p_addr[1] = 5'd10; p_data[1] = 32'h33;
    step(1'b0);
    step(1'b0);

    // Random traffic with withdrawals, marks and occasional reset
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!p_act[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            p_act[i]  = 1'b1;
            p_addr[i] = 5'($urandom_range(0, 31));
            p_data[i] = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          p_act[i] = 1'b0;
        end
      end
      m_en   = ($urandom_range(0, 3) == 0);
      m_addr = 5'($urandom_range(0, 31));
      reset  = ($urandom_range(0, 199) == 0);
      step(1'b0);
    end

    reset = 1'b0;
    m_en  = 1'b0;
    for (int i = 0; i < N; i++) p_act[i] = 1'b0;
    repeat (4) step(1'b0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
